// File: rtl/basic_adder_pkg.sv
// Shared constants for the registered one-bit adder.
// ADDER_INPUT_REG_EN adds an input register stage and stretches latency to 2.
package basic_adder_pkg;

`ifdef ADDER_INPUT_REG_EN
  localparam int ADDER_LATENCY = 2;
`else
  localparam int ADDER_LATENCY = 1;
`endif

  localparam logic SUM_RST_DEFAULT  = 1'b0;
  localparam logic COUT_RST_DEFAULT = 1'b0;

endpackage

// File: rtl/full_adder_comb.sv
// Purely combinational one-bit full adder cell.
module full_adder_comb
  import basic_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  // Sum is odd parity of the three inputs; carry is the majority vote.
  always_comb begin
    sum_o  = a_i ^ b_i ^ cin_i;
    cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
  end

endmodule

// File: rtl/basic_one_bit_adder.sv
// Registered one-bit full adder: sum/cout come straight from flip-flops.
// Optional macro ADDER_INPUT_REG_EN registers a/b/cin first (2-cycle latency).
// Port order is kept so legacy positional instantiations still bind.
module basic_one_bit_adder
  import basic_adder_pkg::*;
#(
  parameter logic SUM_RST  = SUM_RST_DEFAULT,
  parameter logic COUT_RST = COUT_RST_DEFAULT
) (
  input  logic cin,
  input  logic a,
  input  logic b,
  input  logic clk,
  output logic sum,
  output logic cout,
  input  logic rst_n
);

  logic add_a;
  logic add_b;
  logic add_cin;
  logic sum_d;
  logic cout_d;
  logic sum_q;
  logic cout_q;

`ifdef ADDER_INPUT_REG_EN
  logic a_q;
  logic b_q;
  logic cin_q;

  // Input stage: reset to zero so the first post-reset result is 0+0+0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
    end
  end

  assign add_a   = a_q;
  assign add_b   = b_q;
  assign add_cin = cin_q;
`else
  assign add_a   = a;
  assign add_b   = b;
  assign add_cin = cin;
`endif

  full_adder_comb u_full_adder_comb (
    .a_i   (add_a),
    .b_i   (add_b),
    .cin_i (add_cin),
    .sum_o (sum_d),
    .cout_o(cout_d)
  );

  // Output stage: reset wins over a simultaneous edge and drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= SUM_RST;
      cout_q <= COUT_RST;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_basic_one_bit_adder.sv
// Self-checking bench for basic_one_bit_adder (works for either latency build).
module tb_basic_one_bit_adder;
  import basic_adder_pkg::*;

  typedef struct {
    logic  a;
    logic  b;
    logic  cin;
    logic  expSum;
    logic  expCout;
    string name;
  } vecT;

  typedef struct packed {
    logic s;
    logic c;
  } expT;

  logic clk;
  logic clkEn;
  logic rst_n;
  logic a;
  logic b;
  logic cin;
  logic sum;
  logic cout;

  int   assertCount;
  int   failCount;
  logic lastSum;
  logic lastCout;
  expT  sb[$];
  vecT  vecs[8];

  basic_one_bit_adder dut (
    .cin  (cin),
    .a    (a),
    .b    (b),
    .clk  (clk),
    .sum  (sum),
    .cout (cout),
    .rst_n(rst_n)
  );

  // Clock only toggles once enabled, so reset can be exercised with no edges at all.
  always begin
    #5;
    if (clkEn) clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic expSum, input logic expCout);
    assertCount++;
    if (sum !== expSum || cout !== expCout) begin
      failCount++;
      $display("[TB] FAIL %s: sum/cout got %b/%b expected %b/%b", name, sum, cout, expSum, expCout);
    end
  endtask

  task automatic pushExpected(input logic ia, input logic ib, input logic icin);
    logic [1:0] total;
    total = 2'(ia) + 2'(ib) + 2'(icin);
    sb.push_back('{s: total[0], c: total[1]});
  endtask

  task automatic applyStimulus(input logic ia, input logic ib, input logic icin);
    @(negedge clk);
    a   = ia;
    b   = ib;
    cin = icin;
    pushExpected(ia, ib, icin);
  endtask

  task automatic clockAndCheck(input string name);
    expT e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: scoreboard empty got sum/cout %b/%b", name, sum, cout);
    end else begin
      e = sb.pop_front();
      checkOutput(name, e.s, e.c);
      lastSum  = e.s;
      lastCout = e.c;
    end
  endtask

  // After reset the input stage (if any) holds zeros, so pre-seed those results.
  task automatic releaseReset();
    @(negedge clk);
    a     = 1'b0;
    b     = 1'b0;
    cin   = 1'b0;
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < ADDER_LATENCY - 1; i++) sb.push_back('{s: 1'b0, c: 1'b0});
    lastSum  = 1'b0;
    lastCout = 1'b0;
  endtask

  initial begin
    logic [2:0] pat;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "v000"};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "v100"};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "v110"};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "v111"};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "v011"};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "v001"};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "v101"};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "v010"};

    assertCount = 0;
    failCount   = 0;
    lastSum     = 1'b0;
    lastCout    = 1'b0;
    clk         = 1'b0;
    clkEn       = 1'b0;
    rst_n       = 1'b0;
    a           = 1'b0;
    b           = 1'b0;
    cin         = 1'b0;

    $display("[TB] reset held with no clock");
    #1;
    for (int i = 0; i < 8; i++) begin
      pat = 3'(i);
      {a, b, cin} = pat;
      #3;
      checkOutput("rstNoClk", 1'b0, 1'b0);
    end

    clkEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {a, b, cin} = 3'($urandom_range(7));
      @(posedge clk);
      #1;
      checkOutput("rstWithClk", 1'b0, 1'b0);
    end

    releaseReset();
    #1;
    checkOutput("releasedNoEdge", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    clockAndCheck("firstEdge");

    $display("[TB] exhaustive sweep");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a   = vecs[i].a;
      b   = vecs[i].b;
      cin = vecs[i].cin;
      sb.push_back('{s: vecs[i].expSum, c: vecs[i].expCout});
      clockAndCheck(vecs[i].name);
    end

    $display("[TB] inputs changing twice between edges");
    @(negedge clk);
    a = 1'b1; b = 1'b1; cin = 1'b0;
    #2;
    checkOutput("holdMid1", lastSum, lastCout);
    a = 1'b0; b = 1'b0; cin = 1'b1;
    #1;
    checkOutput("holdMid2", lastSum, lastCout);
    pushExpected(1'b0, 1'b0, 1'b1);
    clockAndCheck("lastWins");

    $display("[TB] random stream");
    for (int i = 0; i < 6; i++) begin
      pat = 3'($urandom_range(7));
      applyStimulus(pat[2], pat[1], pat[0]);
      clockAndCheck("random");
    end

    $display("[TB] reset mid-operation");
    for (int i = 0; i < ADDER_LATENCY + 1; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      clockAndCheck("ones");
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReset", 1'b0, 1'b0);
    a = 1'b1; b = 1'b0; cin = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resetHolds", 1'b0, 1'b0);
    releaseReset();
    #1;
    checkOutput("releasedAgain", 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    clockAndCheck("afterRelease1");
    applyStimulus(1'b0, 1'b0, 1'b0);
    clockAndCheck("afterRelease2");
    applyStimulus(1'b0, 1'b1, 1'b0);
    clockAndCheck("afterRelease3");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/basic_one_bit_adder.md
Name: basic_one_bit_adder

Overview:
Registered 1-bit full adder.
- Samples `a`, `b` and `cin` on each rising clock edge.
- Presents the sum and carry-out as flip-flop outputs.
- Serves as the leaf arithmetic cell for clocked ripple/serial adder datapaths and as a timing-clean demo block.
- Outputs change only at clock edges, never combinationally from the inputs.

Parameters:
- SUM_RST, 1'b0, value loaded into `sum` while reset is asserted.
- COUT_RST, 1'b0, value loaded into `cout` while reset is asserted.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cin  input  1  carry-in.
- a  input  1  addend A.
- b  input  1  addend B.
- sum  output  1  registered sum bit.
- cout  output  1  registered carry-out.

Behaviour:
- Port declaration order in RTL is `cin`, `a`, `b`, `clk`, `sum`, `cout`, `rst_n`. This keeps existing positional instantiations of the form (cin, a, b, clk, sum, cout) binding correctly.
- Reset:
  - `rst_n` low immediately, with no clock required, forces `sum` to SUM_RST and `cout` to COUT_RST.
  - Outputs hold those values while `rst_n` is low.
  - Deassertion is synchronous-safe: the first capture happens at the first rising `clk` edge with `rst_n` high.
- Arithmetic, evaluated on `a`, `b`, `cin` as sampled at the rising edge:
  - sum_next = a XOR b XOR cin.
  - cout_next = (a AND b) OR (a AND cin) OR (b AND cin).
  - Equivalently {cout, sum} = a + b + cin, 2-bit unsigned result, range 0..3, with no overflow.
- Latency: 1 cycle. The result of inputs present at edge N appears after edge N and holds until edge N+1.
- Input changes between edges have no effect on the outputs.
- Inputs changing exactly at the edge follow normal setup/hold rules; the bench must drive inputs away from edges.
- Reset asserted mid-operation discards any in-flight result.
- Reset and a clock edge arriving together: reset wins.
- X/Z on an input propagates as X on the affected output. No X filtering.

Optional Feature:
Macro ADDER_INPUT_REG_EN.
- When defined:
  - Adds an input register stage on `a`, `b` and `cin`, reset to 0 by `rst_n`.
  - Total latency becomes 2 cycles: inputs at edge N produce outputs after edge N+1.
  - During the first cycle after reset deassertion the outputs reflect 0+0+0, i.e. sum=0, cout=0.
- When undefined: single output register stage with 1-cycle latency, exactly as in Behaviour.
- The port list is identical in both builds.

Decomposition:
- Package basic_adder_pkg:
  - ADDER_LATENCY constant, 1 or 2 depending on the macro.
  - Default reset-value constants used by SUM_RST and COUT_RST.
- One natural sub-module, full_adder_comb: a purely combinational a/b/cin to sum/cout cell.
  - The top instantiates it and registers its outputs, plus the input registers when ADDER_INPUT_REG_EN is defined.

Test Plan:
1. Hold `rst_n`=0 and toggle inputs with any values -> `sum`=0 and `cout`=0 throughout, even with no clock edges.
2. Release reset with a=b=cin=0 and apply one clock edge -> sum=0, cout=0.
3. Exhaustive sweep (1-cycle build): apply each of the 8 input combinations mid-cycle, then apply a rising edge.
   - Expected (a, b, cin) -> (sum, cout): 100->10, 110->01, 111->11, 011->01, 001->10, 101->01, 010->10.
4. Change inputs twice between two edges, e.g. 1,1,0 then 0,0,1 -> outputs update only at the edge and reflect the last value (sum=1, cout=0).
5. Assert `rst_n` low mid-cycle while the outputs show 1,1 -> outputs drop to 0,0 immediately. They stay 0,0 until the first edge after release.
6. With ADDER_INPUT_REG_EN defined, apply a=b=cin=1 before edge N -> outputs stay at their previous value after edge N and become sum=1, cout=1 after edge N+1.
